dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the wait states inserted between request accept and response (range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: the core presents a load or store request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, 3 bits: RV32I load/store funct3 (size and sign).
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load data, extended to 32 bits; 0 for stores and for errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request was faulted.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on a clock edge where req_valid and req_ready are both 1, and capture addr, wdata, we and funct3 at that edge.
REQ-018 SHALL transition from IDLE to WAIT on accept when WAIT_CYCLES>0, and directly to RESP when WAIT_CYCLES=0.
REQ-019 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a down-counter, and then enter RESP.
REQ-020 SHALL give latency as follows: a request accepted at edge N gives rsp_valid=1 from cycle N+1+WAIT_CYCLES.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-022 SHALL ignore rsp_ready outside RESP.
REQ-023 SHALL allow at most one outstanding request, so the peak rate is one request per WAIT_CYCLES+2 cycles.
REQ-024 SHALL support loads with funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; LB and LH sign-extend, LBU and LHU zero-extend.
REQ-025 SHALL support stores with funct3 000 SB, 001 SH and 010 SW, writing only the addressed byte lanes.
REQ-026 SHALL select lanes by addr[1:0] (byte) or addr[1] (halfword), little-endian.
REQ-027 SHALL commit a store on the edge entering RESP, so a load accepted afterwards returns the new data.
REQ-028 SHALL set rsp_err=1 for a halfword access with addr[0]=1.
REQ-029 SHALL set rsp_err=1 for a word access with addr[1:0]!=0.
REQ-030 SHALL set rsp_err=1 when addr[31:2]>=DEPTH_WORDS.
REQ-031 SHALL set rsp_err=1 for an illegal funct3: loads 011, 110 or 111; stores 011 through 111.
REQ-032 SHALL, on an errored request, suppress the write, return rsp_rdata=0, and still complete the handshake normally.
REQ-033 SHALL ignore req_valid while not in IDLE, with no side effects.

Reset
REQ-034 SHALL, while rst=1, force state IDLE, the counter to 0, rsp_valid=0, rsp_err=0 and rsp_rdata=0; req_ready becomes 1 once rst is deasserted.
REQ-035 SHALL, on reset asserted in WAIT or RESP, abort the request and not commit a pending store.
REQ-036 SHALL not reset storage contents.

Structure
REQ-037 SHALL take the load/store funct3 encodings and the FSM state enum from the shared package rv_pkg.
REQ-038 SHALL place byte-lane steering, write-enable generation and load extension in one combinational sub-module, rv_lsu_align.

Verification
REQ-039 SHALL verify SW then LW: SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> rdata 0xDEADBEEF, err 0.
REQ-040 SHALL verify byte sign handling: SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80 and LBU 0x13 -> 0x00000080; word 0x10 reads 0x80ADBEEF.
REQ-041 SHALL verify misalignment: LW at 0x12 -> err 1, rdata 0; SH at 0x11 -> err 1, memory unchanged.
REQ-042 SHALL verify backpressure with WAIT_CYCLES=3: rsp_valid rises 4 cycles after accept; rsp_ready held 0 for 5 cycles -> outputs stable and req_ready 0 throughout.
REQ-043 SHALL verify reset mid-operation: rst pulsed during WAIT of an SW of 0x12345678 to 0x20 -> IDLE, rsp_valid 0, and LW 0x20 returns the prior value.
REQ-044 SHALL verify range and funct3 faults: LW at word index DEPTH_WORDS -> err 1; load with funct3 110 -> err 1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I load/store encodings and the responder FSM state type.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv_lsu_align.sv
// Combinational byte-lane steering, write-mask generation, fault detection and load extension.
module rv_lsu_align
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rd_word_i,
  output logic        err_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  logic        illegal;
  logic        misalign;
  logic        out_of_range;
  logic [3:0]  mask;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext;

  always_comb begin
    illegal      = we_i ? (funct3_i > F3_W)
                        : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign     = 1'b0;
    if (funct3_i[1:0] == 2'b01)      misalign = addr_i[0];
    else if (funct3_i[1:0] == 2'b10) misalign = |addr_i[1:0];
    out_of_range = {2'b00, addr_i[31:2]} >= DEPTH_L;
    err_o        = illegal | misalign | out_of_range;
  end

  always_comb begin
    mask    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        mask    = 4'b0001 << addr_i[1:0];
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        mask    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        mask    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
    // Faulted stores must never touch memory.
    wmask_o = (we_i && !err_o) ? mask : 4'b0000;
  end

  always_comb begin
    rd_byte = rd_word_i[{addr_i[1:0], 3'b000} +: 8];
    rd_half = addr_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    case (funct3_i)
      F3_B:    ext = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    ext = {{16{rd_half[15]}}, rd_half};
      F3_W:    ext = rd_word_i;
      F3_BU:   ext = {24'd0, rd_byte};
      F3_HU:   ext = {16'd0, rd_half};
      default: ext = 32'd0;
    endcase
    load_o = (!we_i && !err_o) ? ext : 32'd0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: IDLE -> WAIT (WAIT_CYCLES) -> RESP, byte-lane RAM.
module dmem_responder
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic        accept;
  logic        enter_resp;
  logic        commit;
  logic        rd_en;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic        err;
  logic [3:0]  wmask;
  logic [31:0] wdata_lane;
  logic [31:0] load_data;
  logic [31:0] rd_word;
  logic [IDX_W-1:0] idx;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_L;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
      end
    end
  end

  // In IDLE the live bus is the current request so zero-wait accesses can use it on the accept edge.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we     = bus.req_we;
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
      cur_funct3 = bus.req_funct3;
    end else begin
      cur_we     = we_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
      cur_funct3 = funct3_q;
    end
  end

  rv_lsu_align #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_align (
    .we_i      (cur_we),
    .addr_i    (cur_addr),
    .wdata_i   (cur_wdata),
    .funct3_i  (cur_funct3),
    .rd_word_i (rd_word),
    .err_o     (err),
    .wmask_o   (wmask),
    .wdata_o   (wdata_lane),
    .load_o    (load_data)
  );

  assign idx    = err ? '0 : cur_addr[IDX_W+1:2];
  assign commit = enter_resp && !rst;
  // Freeze the read register in RESP so response data stays stable under backpressure.
  assign rd_en  = (state_q != RESP);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (commit && wmask[gi]) mem[idx] <= wdata_lane[gi*8 +: 8];
        if (rd_en)               rd_q     <= mem[idx];
      end

      assign rd_word[gi*8 +: 8] = rd_q;
    end
  endgenerate

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err;
  assign bus.rsp_rdata = (state_q == RESP) ? load_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: functional, fault, backpressure, reset and zero-wait scenarios.
module tb_dmem_responder;
  import rv_pkg::*;

  localparam int DEPTH = 256;
  localparam int W     = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;
  exp_t exp_q[$];

  dmem_responder_if bus3 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    else             pass_cnt++;
  endtask

  // One full transaction on the WAIT_CYCLES=3 instance; hold = cycles rsp_ready stays low.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    exp_t e;
    int   n;
    bit   got;
    logic [31:0] first_rdata;
    logic        first_err;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    bus3.req_we = we; bus3.req_addr = addr; bus3.req_wdata = wdata; bus3.req_funct3 = f3;
    bus3.req_valid = 1'b1;
    chk({name, " req_ready"}, 64'(bus3.req_ready), 64'd1);
    @(posedge clk);
    #1 bus3.req_valid = 1'b0;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (bus3.rsp_valid === 1'b1) got = 1'b1;
    end
    chk({name, " latency"}, 64'(got ? n : 99), 64'(W + 1));
    e = exp_q.pop_front();
    if (got) begin
      chk({name, " rdata"}, 64'(bus3.rsp_rdata), 64'(e.rdata));
      chk({name, " err"},   64'(bus3.rsp_err),   64'(e.err));
      first_rdata = bus3.rsp_rdata;
      first_err   = bus3.rsp_err;
      for (int h = 0; h < hold; h++) begin
        bus3.req_valid = 1'b1; bus3.req_we = 1'b1; bus3.req_addr = 32'h10;
        bus3.req_wdata = 32'hFFFF_FFFF; bus3.req_funct3 = F3_W;
        @(posedge clk);
        @(negedge clk);
        chk({name, " hold"},
            {29'd0, bus3.rsp_valid, bus3.rsp_err, bus3.req_ready, bus3.rsp_rdata},
            {29'd0, 1'b1, first_err, 1'b0, first_rdata});
      end
      bus3.req_valid = 1'b0;
      bus3.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus3.rsp_ready = 1'b0;
      @(negedge clk);
      chk({name, " back to idle"}, {62'd0, bus3.req_ready, bus3.rsp_valid}, 64'b10);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid",  64'(bus3.rsp_valid), 64'd0);
    chk("reset rsp_err",    64'(bus3.rsp_err),   64'd0);
    chk("reset rsp_rdata",  64'(bus3.rsp_rdata), 64'd0);
    chk("reset req_ready",  64'(bus3.req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-reset req_ready", 64'(bus3.req_ready), 64'd1);
    chk("post-reset dut0 idle", {62'd0, bus0.req_ready, bus0.rsp_valid}, 64'b10);
  endtask

  task automatic test_sw_lw();
    do_req("SW 0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, 32'h0, 1'b0, 0);
    do_req("LW 0x10", 1'b0, 32'h10, 32'h0,         F3_W, 32'hDEAD_BEEF, 1'b0, 0);
  endtask

  task automatic test_byte_sign();
    do_req("SB 0x13",  1'b1, 32'h13, 32'h0000_0080, F3_B,  32'h0, 1'b0, 0);
    do_req("LB 0x13",  1'b0, 32'h13, 32'h0, F3_B,  32'hFFFF_FF80, 1'b0, 0);
    do_req("LBU 0x13", 1'b0, 32'h13, 32'h0, F3_BU, 32'h0000_0080, 1'b0, 0);
    do_req("LW word",  1'b0, 32'h10, 32'h0, F3_W,  32'h80AD_BEEF, 1'b0, 0);
    do_req("LH 0x12",  1'b0, 32'h12, 32'h0, F3_H,  32'hFFFF_80AD, 1'b0, 0);
    do_req("LHU 0x10", 1'b0, 32'h10, 32'h0, F3_HU, 32'h0000_BEEF, 1'b0, 0);
  endtask

  task automatic test_misalign();
    do_req("LW 0x12 misalign", 1'b0, 32'h12, 32'h0,    F3_W, 32'h0, 1'b1, 0);
    do_req("SH 0x11 misalign", 1'b1, 32'h11, 32'h1234, F3_H, 32'h0, 1'b1, 0);
    do_req("LW after SH fault", 1'b0, 32'h10, 32'h0,   F3_W, 32'h80AD_BEEF, 1'b0, 0);
  endtask

  task automatic test_faults();
    do_req("LW out of range", 1'b0, 32'(DEPTH * 4), 32'h0, F3_W, 32'h0, 1'b1, 0);
    do_req("load f3 110",     1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1, 0);
    do_req("store f3 011",    1'b1, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    do_req("LW after faults", 1'b0, 32'h10, 32'h0, F3_W, 32'h80AD_BEEF, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_req("LW backpressure", 1'b0, 32'h10, 32'h0, F3_W, 32'h80AD_BEEF, 1'b0, 5);
    do_req("LW after ignored req", 1'b0, 32'h10, 32'h0, F3_W, 32'h80AD_BEEF, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    do_req("SW 0x20 prior", 1'b1, 32'h20, 32'hCAFE_F00D, F3_W, 32'h0, 1'b0, 0);
    @(negedge clk);
    bus3.req_we = 1'b1; bus3.req_addr = 32'h20; bus3.req_wdata = 32'h1234_5678;
    bus3.req_funct3 = F3_W; bus3.req_valid = 1'b1;
    @(posedge clk);
    #1 bus3.req_valid = 1'b0;
    @(negedge clk);
    chk("mid-reset in WAIT", {62'd0, bus3.req_ready, bus3.rsp_valid}, 64'b00);
    rst = 1'b1;
    #1;
    chk("mid-reset rsp_valid", 64'(bus3.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid-reset req_ready", 64'(bus3.req_ready), 64'd1);
    repeat (W + 1) @(negedge clk);
    chk("mid-reset no resp", 64'(bus3.rsp_valid), 64'd0);
    do_req("LW 0x20 prior", 1'b0, 32'h20, 32'h0, F3_W, 32'hCAFE_F00D, 1'b0, 0);
  endtask

  task automatic test_zero_wait();
    exp_t e;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    exp_q.push_back('{rdata: 32'hFFFF_CAFE, err: 1'b0});
    @(negedge clk);
    bus0.req_we = 1'b1; bus0.req_addr = 32'h8; bus0.req_wdata = 32'h0BAD_CAFE;
    bus0.req_funct3 = F3_W; bus0.req_valid = 1'b1;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("W0 SW valid", 64'(bus0.rsp_valid), 64'd1);
    chk("W0 SW resp", {31'd0, bus0.rsp_err, bus0.rsp_rdata}, {31'd0, e.err, e.rdata});
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus0.rsp_ready = 1'b0;
    @(negedge clk);
    bus0.req_we = 1'b0; bus0.req_addr = 32'h8; bus0.req_funct3 = F3_H; bus0.req_valid = 1'b1;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("W0 LH valid", 64'(bus0.rsp_valid), 64'd1);
    chk("W0 LH resp", {31'd0, bus0.rsp_err, bus0.rsp_rdata}, {31'd0, e.err, e.rdata});
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus0.rsp_ready = 1'b0;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = 32'h0;
    bus3.req_wdata = 32'h0; bus3.req_funct3 = 3'd0; bus3.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'h0;
    bus0.req_wdata = 32'h0; bus0.req_funct3 = 3'd0; bus0.rsp_ready = 1'b0;

    test_reset();
    test_sw_lw();
    test_byte_sign();
    test_misalign();
    test_faults();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();

    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard drained: got %0d left, required 0", exp_q.size());
    else                   pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
